// File: rtl/block_transfer_sequencer.sv
// LDM/STM block transfer sequencer: walks a register list one memory beat at a time,
// drives the register file read/write ports, then performs optional base writeback.
module block_transfer_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load,
  input  logic                     pre,
  input  logic                     up,
  input  logic                     wback,
  input  logic [$clog2(NREGS)-1:0] base_reg,
  input  logic [DATA_W-1:0]        base_val,
  input  logic [NREGS-1:0]         reg_list,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(NREGS)-1:0] rf_ra,
  input  logic [DATA_W-1:0]        rf_rd,
  output logic                     rf_we,
  output logic [$clog2(NREGS)-1:0] rf_wa,
  output logic [DATA_W-1:0]        rf_wd,
  output logic                     pc_we,
  output logic [DATA_W-1:0]        pc_wd
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0]  PC_IDX    = IDX_W'(NREGS - 1);
  localparam logic [DATA_W-1:0] WORD_STEP = DATA_W'(3'd4);
  localparam logic [DATA_W-1:0] ALIGN_MSK = {{(DATA_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    WBACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [IDX_W:0] popcount(input logic [NREGS-1:0] m);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + (IDX_W+1)'(m[i]);
    end
    return cnt;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREGS-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  state_t             state_r, state_nx_s;
  logic [NREGS-1:0]   mask_r;
  logic [DATA_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wb_val_r;
  logic [IDX_W-1:0]   base_reg_r;
  logic               load_r;
  logic               wb_en_r;

  logic [IDX_W:0]     n_s;
  logic [DATA_W-1:0]  span_s;
  logic [DATA_W-1:0]  start_addr_s;
  logic [IDX_W-1:0]   cur_s;
  logic [NREGS-1:0]   mask_left_s;

  // Start address and remaining-mask arithmetic
  always_comb begin
    n_s          = popcount(reg_list);
    span_s       = DATA_W'({n_s, 2'b00});
    cur_s        = lowest_idx(mask_r);
    mask_left_s  = mask_r & ~(NREGS'(1'b1) << cur_s);
    start_addr_s = base_val;
    case ({up, pre})
      2'b10:   start_addr_s = base_val;
      2'b11:   start_addr_s = base_val + WORD_STEP;
      2'b00:   start_addr_s = base_val - span_s + WORD_STEP;
      2'b01:   start_addr_s = base_val - span_s;
      default: start_addr_s = base_val;
    endcase
  end

  // State register and transfer context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mask_r     <= '0;
      addr_r     <= '0;
      wb_val_r   <= '0;
      base_reg_r <= '0;
      load_r     <= 1'b0;
      wb_en_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            mask_r     <= reg_list;
            addr_r     <= start_addr_s;
            wb_val_r   <= up ? (base_val + span_s) : (base_val - span_s);
            base_reg_r <= base_reg;
            load_r     <= load;
            // A loaded base wins over writeback; STM keeps the deferred writeback
            wb_en_r    <= wback & ~(load & reg_list[base_reg]);
          end
        end
        XFER: begin
          if (mem_ready) begin
            mask_r <= mask_left_s;
            addr_r <= addr_r + WORD_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and beat outputs
  always_comb begin
    state_nx_s = state_r;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_ra      = '0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    pc_we      = 1'b0;
    pc_wd      = '0;
    if (reset) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nx_s = (reg_list == '0) ? DONE : XFER;
          end else begin
            state_nx_s = IDLE;
          end
        end
        XFER: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_addr = addr_r;
          if (!load_r) begin
            rf_ra     = cur_s;
            mem_wdata = rf_rd;
            mem_we    = mem_ready;
          end else if (mem_ready) begin
            if (cur_s == PC_IDX) begin
              pc_we = 1'b1;
              pc_wd = mem_rdata & ALIGN_MSK;
            end else begin
              rf_we = 1'b1;
              rf_wa = cur_s;
              rf_wd = mem_rdata;
            end
          end else begin
            rf_we = 1'b0;
          end
          if (mem_ready && (mask_left_s == '0)) begin
            state_nx_s = wb_en_r ? WBACK : DONE;
          end else begin
            state_nx_s = XFER;
          end
        end
        WBACK: begin
          busy       = 1'b1;
          rf_we      = 1'b1;
          rf_wa      = base_reg_r;
          rf_wd      = wb_val_r;
          state_nx_s = DONE;
        end
        DONE: begin
          busy       = 1'b1;
          done       = 1'b1;
          state_nx_s = IDLE;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Randomized self-checking bench for block_transfer_sequencer; expected beats are
// derived from the register list, addressing mode and base value with plain arithmetic.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, load, pre, up, wback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic        busy, done, mem_req, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, pc_wd;
  logic        rf_we, pc_we;

  logic [31:0] rfmem [16];
  int checks = 0;
  int failures = 0;

  assign rf_rd = rfmem[rf_ra];

  always #5 clk = ~clk;

  block_transfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .load(load), .pre(pre), .up(up),
    .wback(wback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd)
  );

  // Random request fields; the DUT must ignore them while busy
  task automatic scramble();
    start    = 1'($urandom);
    load     = 1'($urandom);
    pre      = 1'($urandom);
    up       = 1'($urandom);
    wback    = 1'($urandom);
    base_reg = 4'($urandom);
    base_val = $urandom;
    reg_list = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    base_reg = 4'd0; base_val = 32'd0; reg_list = 16'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    for (int i = 0; i < 16; i++) rfmem[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000", {busy, done, mem_req, mem_we, rf_we, pc_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, rf_wd, pc_wd, rf_ra, rf_wa} !== 136'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rf_wd=%h pc_wd=%h ra=%h wa=%h exp=all zero",
               mem_addr, mem_wdata, rf_wd, pc_wd, rf_ra, rf_wa);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, rf_we, pc_we} !== 5'b00000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=00000", {busy, done, mem_req, rf_we, pc_we});
    end
    @(posedge clk); #1;
  endtask

  // One complete transfer; called at posedge+1 with the DUT idle
  task automatic test_transfer(input string name, input logic ld, input logic pr,
                               input logic u, input logic wb, input logic [3:0] br,
                               input logic [31:0] bv, input logic [15:0] lst,
                               input int stall_first, input int stall_pct);
    int regs[$];
    int n, beat, cyc;
    logic [31:0] addr, wbv, rd;
    logic exp_wb, rdy;
    logic [5:0] exp_st;
    for (int i = 0; i < 16; i++) rfmem[i] = $urandom;
    for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
    n = regs.size();
    case ({u, pr})
      2'b10:   addr = bv;
      2'b11:   addr = bv + 32'd4;
      2'b00:   addr = bv - 32'(4 * n) + 32'd4;
      default: addr = bv - 32'(4 * n);
    endcase
    exp_wb = wb && (n != 0) && !(ld && lst[br]);
    wbv = u ? (bv + 32'(4 * n)) : (bv - 32'(4 * n));

    start = 1'b1; load = ld; pre = pr; up = u; wback = wb;
    base_reg = br; base_val = bv; reg_list = lst; mem_ready = 1'($urandom);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle_at_start got=%b exp=000", name, {busy, done, mem_req});
    end
    @(posedge clk); #1;

    beat = 0;
    cyc = 0;
    while (beat < n && cyc < 400) begin
      rdy = (cyc >= stall_first) && ($urandom_range(0, 99) >= stall_pct);
      rd = $urandom;
      scramble();
      mem_ready = rdy;
      mem_rdata = rd;
      @(negedge clk);
      exp_st = {1'b1, 1'b0, 1'b1, !ld && rdy, ld && rdy && regs[beat] != 15,
                ld && rdy && regs[beat] == 15};
      checks++;
      if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== exp_st) begin
        failures++;
        $display("FAIL %s beat_strobes beat=%0d got=%b exp=%b", name, beat,
                 {busy, done, mem_req, mem_we, rf_we, pc_we}, exp_st);
      end
      checks++;
      if (mem_addr !== addr) begin
        failures++;
        $display("FAIL %s beat_addr beat=%0d got=%h exp=%h", name, beat, mem_addr, addr);
      end
      if (!ld) begin
        checks++;
        if (rf_ra !== 4'(regs[beat]) || mem_wdata !== rfmem[regs[beat]]) begin
          failures++;
          $display("FAIL %s stm_data beat=%0d got ra=%0d wdata=%h exp ra=%0d wdata=%h",
                   name, beat, rf_ra, mem_wdata, regs[beat], rfmem[regs[beat]]);
        end
      end else if (rdy && regs[beat] == 15) begin
        checks++;
        if (pc_wd !== (rd & ~32'd3)) begin
          failures++;
          $display("FAIL %s pc_load got=%h exp=%h", name, pc_wd, rd & ~32'd3);
        end
      end else if (rdy) begin
        checks++;
        if (rf_wa !== 4'(regs[beat]) || rf_wd !== rd) begin
          failures++;
          $display("FAIL %s ldm_data beat=%0d got wa=%0d wd=%h exp wa=%0d wd=%h",
                   name, beat, rf_wa, rf_wd, regs[beat], rd);
        end
      end
      if (rdy) begin
        beat++;
        addr = addr + 32'd4;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (beat < n) begin
      failures++;
      $display("FAIL %s beat_timeout got=%0d beats exp=%0d", name, beat, n);
    end

    if (exp_wb) begin
      scramble();
      mem_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b100010 ||
          rf_wa !== br || rf_wd !== wbv) begin
        failures++;
        $display("FAIL %s writeback got st=%b wa=%0d wd=%h exp st=100010 wa=%0d wd=%h", name,
                 {busy, done, mem_req, mem_we, rf_we, pc_we}, rf_wa, rf_wd, br, wbv);
      end
      @(posedge clk); #1;
    end

    scramble();
    mem_ready = 1'($urandom);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we, rf_we, pc_we} !== 6'b110000) begin
      failures++;
      $display("FAIL %s done_cycle got=%b exp=110000", name,
               {busy, done, mem_req, mem_we, rf_we, pc_we});
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, rf_we, pc_we} !== 5'b00000) begin
      failures++;
      $display("FAIL %s back_to_idle got=%b exp=00000", name, {busy, done, mem_req, rf_we, pc_we});
    end
    @(posedge clk); #1;
  endtask

  // Reset on the second beat of a four-register LDM aborts the transfer
  task automatic test_abort();
    logic [31:0] bv;
    bv = $urandom & ~32'd3;
    start = 1'b1; load = 1'b1; pre = 1'b0; up = 1'b1; wback = 1'b1;
    base_reg = 4'd1; base_val = bv; reg_list = 16'h00F0; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; load = 1'b0; base_val = 32'hDEAD_0000; reg_list = 16'h0001;
    mem_ready = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_wa !== 4'd4 || mem_addr !== bv) begin
      failures++;
      $display("FAIL abort_first_beat got we=%b wa=%0d addr=%h exp we=1 wa=4 addr=%h",
               rf_we, rf_wa, mem_addr, bv);
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({busy, done, mem_req, rf_we, pc_we} !== 5'b00000) begin
        failures++;
        $display("FAIL abort_idle cycle=%0d got=%b exp=00000", k, {busy, done, mem_req, rf_we, pc_we});
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_transfer("stm_ia_wb", 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0000_0100, 16'h0013, 0, 0);
    test_transfer("ldm_db_pc", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_0200, 16'h8006, 0, 0);
    test_transfer("ldm_base_in_list", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0000_0300, 16'h0006, 0, 0);
    test_transfer("stm_ib_stall", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0000_0400, 16'h0001, 3, 0);
    test_transfer("empty_list", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_0500, 16'h0000, 0, 0);
    test_transfer("stm_base_in_list", 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_0600, 16'h0003, 0, 0);
    test_transfer("stm_da_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 32'h0000_0004, 16'hA505, 0, 20);
    test_abort();
    test_transfer("after_abort", 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_0800, 16'h00F0, 0, 0);
    for (int t = 0; t < 30; t++) begin
      test_transfer("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom, 16'($urandom), 0, 30);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Multi-cycle sequencer for ARMv4 LDM/STM block transfers.
- Walks a 16-bit register list and drives the register file read port (STM) or write port (LDM) one register per accepted memory beat.
- Performs optional base writeback, then returns the register file to the main datapath.
- Sits beside register_file; the core stalls while busy=1.

Parameters:
- DATA_W, 32, data and address width.
- NREGS, 16, architectural registers; index width is clog2(NREGS)=4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request new transfer; sampled only in IDLE
- load  in  1  1=LDM, 0=STM
- pre  in  1  P bit: 1=before, 0=after
- up  in  1  U bit: 1=increment, 0=decrement
- wback  in  1  W bit: base writeback enable
- base_reg  in  4  base register index
- base_val  in  32  base register value at start
- reg_list  in  16  register list, bit i = Ri
- busy  out  1  high from cycle after accepted start through DONE
- done  out  1  one-cycle pulse in DONE
- mem_req  out  1  memory beat valid
- mem_ready  in  1  memory accepts/returns beat this cycle
- mem_we  out  1  store strobe (STM, mem_req&mem_ready)
- mem_addr  out  32  word address of current beat
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid when mem_ready
- rf_ra  out  4  register file read address (STM)
- rf_rd  in  32  register file read data, combinational
- rf_we  out  1  register file write enable
- rf_wa  out  4  register file write address
- rf_wd  out  32  register file write data
- pc_we  out  1  load to R15 (PC redirect)
- pc_wd  out  32  PC value for pc_we

Behaviour:
- Reset: state=IDLE; busy, done, mem_req, mem_we, rf_we and pc_we are 0; all address and data outputs are 0. Reset mid-transfer aborts immediately, with no further beats and no writeback.
- States: IDLE -> XFER -> (WBACK) -> DONE -> IDLE.
- IDLE: on start=1, latch load, pre, up, wback, base_reg, base_val and reg_list into the mask. Compute n=popcount(reg_list). Go to XFER, or go to DONE if reg_list=0; an empty list means no beats and no writeback.
- start while busy is ignored.
- Start address (always ascending, lowest register first):
  - IA: base
  - IB: base+4
  - DA: base-4n+4
  - DB: base-4n
  - All arithmetic is mod 2^32.
- XFER:
  - mem_req=1; cur = lowest set bit of mask; mem_addr = current address.
  - STM: rf_ra=cur and mem_wdata=rf_rd combinationally; mem_we = mem_ready.
  - LDM: when mem_ready, rf_we=1, rf_wa=cur, rf_wd=mem_rdata. If cur=15, rf_we=0 and instead pc_we=1, pc_wd=mem_rdata with bits[1:0] cleared.
  - On mem_ready: clear cur from mask and add 4 to the address.
  - mem_ready=0: hold all outputs stable; no state change.
  - After the last beat (mask becomes 0): go to WBACK if wback=1 and not (load and base_reg in list); otherwise go to DONE.
- WBACK, 1 cycle: rf_we=1, rf_wa=base_reg, rf_wd = base+4n if up, else base-4n. mem_req=0.
- DONE, 1 cycle: done=1, busy=1, then IDLE.
- rf_we and pc_we are never asserted outside XFER/WBACK. The core must not drive the write port while busy=1.
- STM with base in list stores the original base value: the write-back is deferred to WBACK.
- Latency: n=0 gives 2 cycles (IDLE->DONE->IDLE). Otherwise 1 + n + stall cycles + wb + 1.

Test Plan:
- STM IA, base=0x100, list=0x0013 (R0,R1,R4), W=1, mem_ready=1 -> beats at 0x100/0x104/0x108 with rf_ra 0,1,4. WBACK writes R(base)=0x10C. done pulses 5 cycles after start.
- LDM DB, base=0x200, list=0x8006 (R1,R2,R15) -> addresses 0x1F4, 0x1F8, 0x1FC. R1 and R2 written from mem_rdata. R15 beat gives pc_we=1, pc_wd=rdata&~3, rf_we=0.
- LDM IA, base_reg=2 in list 0x0006, W=1 -> R2 gets the loaded word and there is no WBACK: the DONE cycle follows the last beat directly.
- STM IB, list=0x0001, mem_ready low for 3 cycles -> mem_addr=base+4 and mem_req held 4 cycles. A single mem_we pulse occurs on the ready cycle.
- list=0x0000, W=1 -> no mem_req, no rf_we; done pulses the cycle after start.
- reset asserted on the 2nd beat of a 4-register LDM -> next cycle IDLE, busy=0, no further rf_we. A start asserted during busy is ignored.
